// File: rtl/pa_ifu_icache_refill_ctrl.sv
// I-cache line refill controller: critical-word-first beat capture,
// one-cycle write stage into the data array, fetch read arbitration.
module pa_ifu_icache_refill_ctrl (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        refill_req_vld,
  input  logic [31:0] refill_req_addr,
  input  logic        refill_req_way,
  input  logic        biu_ifu_rdata_vld,
  input  logic [31:0] biu_ifu_rdata,
  input  logic        biu_ifu_rerr,
  input  logic        ifu_rd_req,
  input  logic [12:0] ifu_rd_idx,
  output logic        ifu_rd_gnt,
  output logic [1:0]  icache_data_cen,
  output logic [1:0]  icache_data_wen,
  output logic [12:0] icache_data_idx,
  output logic [31:0] icache_data_din,
  output logic        refill_busy,
  output logic        refill_done,
  output logic        refill_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t      state;
  logic [10:0] set_q;
  logic        way_q;
  logic [1:0]  wptr;
  logic [1:0]  bcnt;
  logic        wr_vld;
  logic        wr_way;
  logic [12:0] wr_idx;
  logic [31:0] wr_data;
  logic        req_acc;
  logic        beat_acc;
  logic        addr_unused;

  assign refill_busy = (state == REFILL) | wr_vld;

  // the last write cycle still counts as busy, so no back-to-back accept
  assign req_acc  = (state == IDLE) & refill_req_vld & ~wr_vld;
  assign beat_acc = (state == REFILL) & biu_ifu_rdata_vld;

  assign ifu_rd_gnt = cpurst_b & ifu_rd_req
                    & ~refill_busy & ~refill_req_vld;

  assign addr_unused = ^{refill_req_addr[31:15],
                         refill_req_addr[1:0]};

  // refill FSM, beat capture and the registered write stage
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state       <= IDLE;
      set_q       <= '0;
      way_q       <= 1'b0;
      wptr        <= '0;
      bcnt        <= '0;
      wr_vld      <= 1'b0;
      wr_way      <= 1'b0;
      wr_idx      <= '0;
      wr_data     <= '0;
      refill_done <= 1'b0;
      refill_err  <= 1'b0;
    end else begin
      wr_vld      <= 1'b0;
      refill_done <= 1'b0;
      refill_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_acc) begin
            state <= REFILL;
            set_q <= refill_req_addr[14:4];
            way_q <= refill_req_way;
            wptr  <= refill_req_addr[3:2];
            bcnt  <= 2'd0;
          end
        end
        REFILL: begin
          if (beat_acc) begin
            if (biu_ifu_rerr) begin
              state      <= IDLE;
              refill_err <= 1'b1;
            end else begin
              wr_vld  <= 1'b1;
              wr_way  <= way_q;
              wr_idx  <= {set_q, wptr};
              wr_data <= biu_ifu_rdata;
              wptr    <= wptr + 2'd1;
              bcnt    <= bcnt + 2'd1;
              if (bcnt == 2'd3) begin
                state       <= IDLE;
                refill_done <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  // array port mux: refill write, else granted read, else quiet
  always_comb begin
    icache_data_cen = 2'b00;
    icache_data_wen = 2'b00;
    icache_data_idx = '0;
    icache_data_din = '0;
    unique case (1'b1)
      wr_vld: begin
        icache_data_cen = {wr_way, ~wr_way};
        icache_data_wen = {wr_way, ~wr_way};
        icache_data_idx = wr_idx;
        icache_data_din = wr_data;
      end
      ifu_rd_gnt: begin
        icache_data_cen = 2'b11;
        icache_data_idx = ifu_rd_idx;
      end
      default: begin
        icache_data_cen = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_pa_ifu_icache_refill_ctrl.sv
// Directed bench for the i-cache refill controller.
// Expected values are hand-computed from addresses and beat data.
module tb_pa_ifu_icache_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_vld;
  logic [31:0] req_addr;
  logic        req_way;
  logic        b_vld;
  logic [31:0] b_data;
  logic        b_err;
  logic        rd_req;
  logic [12:0] rd_idx;
  logic        rd_gnt;
  logic [1:0]  cen;
  logic [1:0]  wen;
  logic [12:0] idx;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk;
  int n_fail;

  logic [31:0] dat [4];

  pa_ifu_icache_refill_ctrl dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (rst_n),
    .refill_req_vld    (req_vld),
    .refill_req_addr   (req_addr),
    .refill_req_way    (req_way),
    .biu_ifu_rdata_vld (b_vld),
    .biu_ifu_rdata     (b_data),
    .biu_ifu_rerr      (b_err),
    .ifu_rd_req        (rd_req),
    .ifu_rd_idx        (rd_idx),
    .ifu_rd_gnt        (rd_gnt),
    .icache_data_cen   (cen),
    .icache_data_wen   (wen),
    .icache_data_idx   (idx),
    .icache_data_din   (din),
    .refill_busy       (busy),
    .refill_done       (done),
    .refill_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_arr(input string tag,
                         input logic [1:0] c,
                         input logic [1:0] w,
                         input logic [12:0] i,
                         input logic [31:0] d);
    logic [48:0] o;
    logic [48:0] e;
    #1;
    o = {cen, wen, idx, din};
    e = {c, w, i, d};
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s arr cen/wen/idx/din observed=%h expected=%h",
             tag, o, e);
    end
  endtask

  task automatic chk_st(input string tag,
                        input logic b,
                        input logic dn,
                        input logic er,
                        input logic g);
    logic [3:0] o;
    logic [3:0] e;
    #1;
    o = {busy, done, err, rd_gnt};
    e = {b, dn, er, g};
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s busy/done/err/gnt observed=%b expected=%b",
             tag, o, e);
    end
  endtask

  initial begin
    logic [1:0] wd;
    n_chk  = 0;
    n_fail = 0;
    dat[0] = 32'hD0D0_0000;
    dat[1] = 32'hD1D1_1111;
    dat[2] = 32'hD2D2_2222;
    dat[3] = 32'hD3D3_3333;
    rst_n    = 1'b0;
    req_vld  = 1'b0;
    req_addr = '0;
    req_way  = 1'b0;
    b_vld    = 1'b0;
    b_data   = '0;
    b_err    = 1'b0;
    rd_req   = 1'b1;
    rd_idx   = 13'h0A5;

    // reset: everything quiet, read not granted
    chk_st("rst_st", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_arr("rst_arr", 2'b00, 2'b00, 13'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // idle read granted
    chk_st("rd_idle_st", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_arr("rd_idle_arr", 2'b11, 2'b00, 13'h0A5, 32'h0);

    // refill + read same cycle: refill wins
    req_vld  = 1'b1;
    req_addr = 32'h0000_1238;
    req_way  = 1'b1;
    chk_st("prio_st", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_arr("prio_arr", 2'b00, 2'b00, 13'h0, 32'h0);
    tick();
    req_vld = 1'b0;
    chk_st("t1_busy", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_arr("t1_quiet", 2'b00, 2'b00, 13'h0, 32'h0);
    b_vld  = 1'b1;
    b_data = dat[0];
    tick();
    b_data = dat[1];
    chk_arr("t1_w0", 2'b10, 2'b10, {11'h123, 2'd2}, dat[0]);
    chk_st("t1_w0_st", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    b_data = dat[2];
    chk_arr("t1_w1", 2'b10, 2'b10, {11'h123, 2'd3}, dat[1]);
    tick();
    b_data = dat[3];
    chk_arr("t1_w2", 2'b10, 2'b10, {11'h123, 2'd0}, dat[2]);
    tick();
    b_vld   = 1'b0;
    req_vld = 1'b1;
    chk_arr("t1_w3", 2'b10, 2'b10, {11'h123, 2'd1}, dat[3]);
    chk_st("t1_done", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    req_vld = 1'b0;
    chk_st("t1_noacc", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_arr("t1_rd", 2'b11, 2'b00, 13'h0A5, 32'h0);

    // spaced beats, way 0, start word 1
    req_vld  = 1'b1;
    req_addr = 32'h0000_7FF4;
    req_way  = 1'b0;
    tick();
    req_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_vld  = 1'b1;
      b_data = dat[k];
      chk_st("t2_beat", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_arr("t2_beat_arr", 2'b00, 2'b00, 13'h0, 32'h0);
      tick();
      b_vld = 1'b0;
      wd = 2'd1 + k[1:0];
      chk_arr("t2_wr", 2'b01, 2'b01, {11'h7FF, wd}, dat[k]);
      chk_st("t2_wr_st", 1'b1, k == 3, 1'b0, 1'b0);
      tick();
      if (k < 3) begin
        chk_st("t2_gap", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_arr("t2_gap_arr", 2'b00, 2'b00, 13'h0, 32'h0);
        tick();
      end
    end
    chk_st("t2_end", 1'b0, 1'b0, 1'b0, 1'b1);
    rd_req = 1'b0;

    // bus error on 3rd beat
    req_vld  = 1'b1;
    req_addr = 32'h0000_0040;
    req_way  = 1'b1;
    tick();
    req_vld = 1'b0;
    b_vld   = 1'b1;
    b_data  = dat[0];
    tick();
    b_data = dat[1];
    chk_arr("t3_w0", 2'b10, 2'b10, 13'h010, dat[0]);
    tick();
    b_data = dat[2];
    b_err  = 1'b1;
    chk_arr("t3_w1", 2'b10, 2'b10, 13'h011, dat[1]);
    tick();
    b_vld = 1'b0;
    b_err = 1'b0;
    chk_arr("t3_nowr", 2'b00, 2'b00, 13'h0, 32'h0);
    chk_st("t3_err", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_st("t3_after", 1'b0, 1'b0, 1'b0, 1'b0);
    b_vld  = 1'b1;
    b_data = dat[3];
    tick();
    b_vld = 1'b0;
    chk_arr("t3_drop", 2'b00, 2'b00, 13'h0, 32'h0);
    chk_st("t3_drop_st", 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-refill
    req_vld  = 1'b1;
    req_addr = 32'h0000_0100;
    req_way  = 1'b0;
    tick();
    req_vld = 1'b0;
    b_vld   = 1'b1;
    b_data  = dat[0];
    tick();
    b_data = dat[1];
    chk_arr("t4_w0", 2'b01, 2'b01, 13'h040, dat[0]);
    tick();
    b_vld = 1'b0;
    chk_arr("t4_w1", 2'b01, 2'b01, 13'h041, dat[1]);
    rst_n  = 1'b0;
    rd_req = 1'b1;
    chk_arr("t4_rst_arr", 2'b00, 2'b00, 13'h0, 32'h0);
    chk_st("t4_rst_st", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n  = 1'b1;
    rd_req = 1'b0;
    b_vld  = 1'b1;
    b_data = dat[2];
    tick();
    chk_arr("t4_post0", 2'b00, 2'b00, 13'h0, 32'h0);
    chk_st("t4_post0_st", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    b_vld = 1'b0;
    chk_arr("t4_post1", 2'b00, 2'b00, 13'h0, 32'h0);
    chk_st("t4_post1_st", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
